// File: rtl/cmos_pkg.sv
// Shared types for the CMOS frame capture controller.
// State encoding and frame error cause bit positions.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    ARM,
    ACTIVE
  } cap_state_e;

  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_LINES = 2;
  localparam int ERR_W     = 3;

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Pixel stream bundle: sync/valid/data in, gated stream out.
// Master drives the raw stream, slave is the capture controller.
interface cmos_capture_ctrl_if;

  logic        vs_i;
  logic        de_i;
  logic [15:0] pdata_i;
  logic        de_o;
  logic [15:0] pdata_o;
  logic        sof_o;
  logic        eol_o;

  modport master (
    output vs_i, de_i, pdata_i,
    input  de_o, pdata_o, sof_o, eol_o
  );

  modport slave (
    input  vs_i, de_i, pdata_i,
    output de_o, pdata_o, sof_o, eol_o
  );

endinterface

// File: rtl/cmos_geom_counter.sv
// Per-frame x/y counting, pass/drop window and geometry errors.
// Counters saturate one past the expected size.
module cmos_geom_counter
  import cmos_pkg::*;
#(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             de_i,
  output logic             pass_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             y_ok_o,
  output logic [ERR_W-1:0] err_o
);

  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_ACT + 1);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_ACT + 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             de_q;
  logic             in_win;
  logic             line_end;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    err_o    = '0;
    in_win   = (x_q < H_LIM) && (y_q < V_LIM);
    line_end = en_i && de_q && !de_i;
    pass_o   = en_i && de_i && in_win;
    sof_o    = pass_o && (x_q == '0) && (y_q == '0);
    eol_o    = pass_o && (x_q == H_LIM - ONE);
    y_ok_o   = (y_q == V_LIM);
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i && de_i) begin
      if (x_q != X_MAX) x_d = x_q + ONE;
      if (y_q >= V_LIM) err_o[ERR_LINES] = 1'b1;
      else if (x_q >= H_LIM) err_o[ERR_LONG] = 1'b1;
    end else if (line_end) begin
      if (x_q < H_LIM) err_o[ERR_SHORT] = 1'b1;
      if (x_q > H_LIM) err_o[ERR_LONG] = 1'b1;
      x_d = '0;
      if (y_q != Y_MAX) y_d = y_q + ONE;
    end
  end

  // de history only tracks counted cycles, so a dropped
  // vsync-cycle pixel cannot fake a line end.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= en_i & de_i;
    end
  end

endmodule

// File: rtl/cmos_capture_ctrl.sv
// Frame capture controller: start/stop, settling skip,
// vsync-aligned whole-frame gating and per-frame status.
module cmos_capture_ctrl
  import cmos_pkg::*;
#(
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int SKIP_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                cont_i,
  cmos_capture_ctrl_if.slave  pix,
  output logic                frame_done_o,
  output logic                frame_err_o,
  output logic                busy_o,
  output logic [15:0]         frame_cnt_o
);

  localparam logic [3:0] SKIP_N = 4'(SKIP_FRAMES);

  cap_state_e       state_q, state_d;
  logic [3:0]       skip_q, skip_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic             vs_q;
  logic             vs_rise, arm, close, clr, en;
  logic             pass, sof, eol, y_ok, err_set;
  logic [ERR_W-1:0] geom_err;
  logic             de_q, sof_q, eol_q, done_q, err_q, busy_q;
  logic [15:0]      pdata_q, cnt_q;

  assign vs_rise = pix.vs_i & ~vs_q;
  assign en      = (state_q == ACTIVE) & ~vs_rise;
  assign err_set = (|geom_err) | (close & ~y_ok);

  cmos_geom_counter #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT),
    .CNT_W (CNT_W)
  ) u_geom (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .en_i   (en),
    .de_i   (pix.de_i),
    .pass_o (pass),
    .sof_o  (sof),
    .eol_o  (eol),
    .y_ok_o (y_ok),
    .err_o  (geom_err)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    arm     = 1'b0;
    close   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          arm     = 1'b1;
          cont_d  = cont_i;
          skip_d  = SKIP_N;
          state_d = (SKIP_N != 4'd0) ? SKIP : ARM;
        end
      end
      SKIP: begin
        if (stop_q) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          skip_d = skip_q - 4'd1;
          if (skip_q == 4'd1) begin
            state_d = ACTIVE;
            clr     = 1'b1;
          end
        end
      end
      ARM: begin
        if (stop_q) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          state_d = ACTIVE;
          clr     = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          close = 1'b1;
          if (cont_q && !stop_q) clr = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && stop_i) stop_d = 1'b1;
    if (state_d == IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      skip_q  <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      pdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      vs_q    <= pix.vs_i;
      de_q    <= pass;
      sof_q   <= sof;
      eol_q   <= eol;
      if (pass) pdata_q <= pix.pdata_i;
      done_q  <= close;
      busy_q  <= (state_q != IDLE);
      if (arm) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (close) cnt_q <= cnt_q + 16'd1;
        if (err_set) err_q <= 1'b1;
      end
    end
  end

  assign pix.de_o     = de_q;
  assign pix.pdata_o  = pdata_q;
  assign pix.sof_o    = sof_q;
  assign pix.eol_o    = eol_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = busy_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Scoreboard bench for cmos_capture_ctrl with a 4x3 frame,
// one settling frame, directed frame sequences.
module tb_cmos_capture_ctrl;

  localparam int H = 4;
  localparam int V = 3;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
  } px_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        err;
  } fd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic        done, err, busy;
  logic [15:0] cnt;
  logic [15:0] pv = 16'h1000;

  px_t exp_px[$];
  fd_t exp_fd[$];
  px_t mon_px;
  fd_t mon_fd;

  int checks = 0;
  int failures = 0;

  cmos_capture_ctrl_if pix();

  cmos_capture_ctrl #(
    .H_ACT       (H),
    .V_ACT       (V),
    .SKIP_FRAMES (1),
    .CNT_W       (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .stop_i       (stop),
    .cont_i       (cont),
    .pix          (pix),
    .frame_done_o (done),
    .frame_err_o  (err),
    .busy_o       (busy),
    .frame_cnt_o  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pix.de_o === 1'b1) begin
      if (exp_px.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL px_unexpected: got data %0h expected none",
                 pix.pdata_o);
      end else begin
        mon_px = exp_px.pop_front();
        chk("px_data", pix.pdata_o, mon_px.d);
        chk("px_sof", pix.sof_o, mon_px.sof);
        chk("px_eol", pix.eol_o, mon_px.eol);
      end
    end
    if (done === 1'b1) begin
      if (exp_fd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got cnt %0d expected none", cnt);
      end else begin
        mon_fd = exp_fd.pop_front();
        chk("fd_cnt", cnt, mon_fd.cnt);
        chk("fd_err", err, mon_fd.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(bit c);
    cont = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_line(int n, bit cap, int y);
    for (int i = 0; i < n; i++) begin
      pix.de_i = 1'b1;
      pix.pdata_i = pv;
      if (cap && i < H)
        exp_px.push_back(px_t'{pv, (y == 0 && i == 0), (i == H - 1)});
      pv++;
      tick();
    end
    pix.de_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_frame(bit cap);
    for (int y = 0; y < V; y++) send_line(H, cap, y);
  endtask

  task automatic vs_pulse(bit cl, logic [15:0] ecnt, bit eerr, bit with_de);
    if (cl) exp_fd.push_back(fd_t'{ecnt, eerr});
    pix.vs_i = 1'b1;
    if (with_de) begin
      pix.de_i = 1'b1;
      pix.pdata_i = pv;
      pv++;
    end
    tick();
    chk("done_latency", done, cl);
    pix.vs_i = 1'b0;
    pix.de_i = 1'b0;
    tick();
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_de_o"}, pix.de_o, 0);
    chk({tag, "_pdata_o"}, pix.pdata_o, 0);
    chk({tag, "_sof_o"}, pix.sof_o, 0);
    chk({tag, "_eol_o"}, pix.eol_o, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pix.vs_i = 1'b0;
    pix.de_i = 1'b0;
    pix.pdata_i = '0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // single frame: start lands mid frame 1
    vs_pulse(0, 0, 0, 0);
    pulse_start(0);
    send_frame(0);
    chk("s1_busy_skip", busy, 1);
    vs_pulse(0, 0, 0, 0);
    send_frame(1);
    vs_pulse(1, 16'd1, 0, 0);
    chk("s1_busy_after", busy, 0);
    send_frame(0);
    chk("s1_cnt", cnt, 1);
    chk("s1_err", err, 0);

    // continuous with stop during frame 3
    vs_pulse(0, 0, 0, 0);
    pulse_start(1);
    send_frame(0);
    vs_pulse(0, 0, 0, 0);
    send_frame(1);
    vs_pulse(1, 16'd1, 0, 0);
    chk("s2_busy_cont", busy, 1);
    send_line(H, 1, 0);
    pulse_stop();
    send_line(H, 1, 1);
    send_line(H, 1, 2);
    vs_pulse(1, 16'd2, 0, 0);
    send_frame(0);
    chk("s2_cnt", cnt, 2);
    chk("s2_busy", busy, 0);

    // short line
    vs_pulse(0, 0, 0, 0);
    pulse_start(0);
    chk("s3_cnt_clear", cnt, 0);
    send_frame(0);
    vs_pulse(0, 0, 0, 0);
    send_line(H, 1, 0);
    chk("s3_err_before", err, 0);
    send_line(3, 1, 1);
    chk("s3_err_short", err, 1);
    send_line(H, 1, 2);
    vs_pulse(1, 16'd1, 1, 0);
    chk("s3_busy", busy, 0);

    // overlong frame, then restart clears status
    vs_pulse(0, 0, 0, 0);
    pulse_start(0);
    chk("s4_err_clear", err, 0);
    send_frame(0);
    vs_pulse(0, 0, 0, 0);
    send_frame(1);
    chk("s4_err_before", err, 0);
    send_line(H, 0, 3);
    chk("s4_err_long", err, 1);
    vs_pulse(1, 16'd1, 1, 0);
    pulse_start(0);
    chk("s4_restart_err", err, 0);
    chk("s4_restart_cnt", cnt, 0);
    pulse_stop();
    tick();
    tick();
    chk("s4_stop_skip_busy", busy, 0);

    // vsync with pixel, then reset mid frame
    vs_pulse(0, 0, 0, 0);
    pulse_start(1);
    send_frame(0);
    vs_pulse(0, 0, 0, 0);
    send_frame(1);
    vs_pulse(1, 16'd1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      pix.de_i = 1'b1;
      pix.pdata_i = pv;
      exp_px.push_back(px_t'{pv, (i == 0), 1'b0});
      pv++;
      tick();
    end
    pix.pdata_i = pv;
    pv++;
    rst = 1'b1;
    tick();
    chk_idle_outputs("midrst");
    rst = 1'b0;
    pix.de_i = 1'b0;
    tick();
    vs_pulse(0, 0, 0, 0);
    send_frame(0);
    vs_pulse(0, 0, 0, 0);
    send_frame(0);
    chk("s5_busy", busy, 0);
    chk("s5_cnt", cnt, 0);

    repeat (3) tick();
    chk("px_queue_empty", exp_px.size(), 0);
    chk("fd_queue_empty", exp_fd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
